// File: rtl/mcpu_alu_arbiter.sv
// rtl/mcpu_alu_arbiter.sv - two-requester arbiter sharing one combinational ALU (IDLE/EXEC/RESP).
// Optional fixed priority (requester 0 wins ties) when MCPU_ALU_ARB_FIXED_PRIO_EN is defined.
module mcpu_alu_arbiter #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic [CMD_SIZE-1:0]    op0,
  input  logic [WORD_SIZE-1:0]   a0,
  input  logic [WORD_SIZE-1:0]   b0,
  input  logic                   req1,
  input  logic [CMD_SIZE-1:0]    op1,
  input  logic [WORD_SIZE-1:0]   a1,
  input  logic [WORD_SIZE-1:0]   b1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   done0,
  output logic                   done1,
  output logic [2*WORD_SIZE-1:0] result,
  output logic                   ovf,
  output logic                   busy,
  output logic [CMD_SIZE-1:0]    alu_opcode,
  output logic [WORD_SIZE-1:0]   alu_r1,
  output logic [WORD_SIZE-1:0]   alu_r2,
  input  logic [2*WORD_SIZE-1:0] alu_out,
  input  logic                   alu_overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_next;
  logic   owner;
  logic   last_grant;
  logic   winner;
  logic   accept;

  // winner only matters when at least one request is high
  always_comb begin
`ifdef MCPU_ALU_ARB_FIXED_PRIO_EN
    winner = req0 ? 1'b0 : (req1 ? 1'b1 : last_grant);
`else
    if (req0 && req1) winner = ~last_grant;
    else              winner = ~req0;
`endif
  end

  assign accept = (state == IDLE) && (req0 || req1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        gnt0       = ~owner;
        gnt1       = owner;
        busy       = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        done0      = ~owner;
        done1      = owner;
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_opcode <= '0;
      alu_r1     <= '0;
      alu_r2     <= '0;
      result     <= '0;
      ovf        <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= winner;
        last_grant <= winner;
        alu_opcode <= winner ? op1 : op0;
        alu_r1     <= winner ? a1 : a0;
        alu_r2     <= winner ? b1 : b0;
      end
      if (state == EXEC) begin
        result <= alu_out;
        ovf    <= alu_overflow;
      end
    end
  end

endmodule

// File: tb/tb_mcpu_alu_arbiter.sv
// tb/tb_mcpu_alu_arbiter.sv - self-checking bench for mcpu_alu_arbiter with a behavioural timing model.
module tb_mcpu_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [7:0]  a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, ovf, busy;
  logic [15:0] result;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_r1, alu_r2;
  logic [15:0] alu_out;
  logic        alu_overflow;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  always #5 clk = ~clk;

  mcpu_alu_arbiter #(.CMD_SIZE(2), .WORD_SIZE(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .ovf(ovf), .busy(busy),
    .alu_opcode(alu_opcode), .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_out(alu_out), .alu_overflow(alu_overflow)
  );

  // returns {overflow, out}; ADD carry lands in bit 8 and in overflow
  function automatic logic [16:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      2'b00:   return {1'b0, 8'h00, a & b};
      2'b01:   return {1'b0, 8'h00, a | b};
      2'b10:   return {1'b0, 8'h00, a ^ b};
      default: return {sum[8], 7'h00, sum};
    endcase
  endfunction

  assign {alu_overflow, alu_out} = alu_fn(alu_opcode, alu_r1, alu_r2);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // model: cycles of work left for the accepted op (2 = gnt cycle, 1 = done cycle)
  int          m_left = 0;
  bit          m_last = 1, m_owner = 0, w;
  logic [1:0]  m_op = 0;
  logic [7:0]  m_a = 0, m_b = 0;
  logic [15:0] m_res = 0;
  logic        m_ovf = 0;
  logic [16:0] m_pend = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_last = 1; m_owner = 0;
      m_op = 0; m_a = 0; m_b = 0; m_res = 0; m_ovf = 0;
    end else if (m_left == 2) begin
      {m_ovf, m_res} = m_pend;
      m_left = 1;
    end else if (m_left == 1) begin
      m_left = 0;
    end else if (req0 || req1) begin
`ifdef MCPU_ALU_ARB_FIXED_PRIO_EN
      w = (req0 && req1) ? 1'b0 : req1;
`else
      w = (req0 && req1) ? !m_last : req1;
`endif
      m_owner = w; m_last = w;
      m_op = w ? op1 : op0;
      m_a  = w ? a1 : a0;
      m_b  = w ? b1 : b0;
      m_pend = alu_fn(m_op, m_a, m_b);
      m_left = 2;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cycle_outputs",
            {gnt0, gnt1, done0, done1, busy, ovf, alu_opcode, alu_r1, alu_r2, result},
            {(m_left == 2) && !m_owner, (m_left == 2) && m_owner,
             (m_left == 1) && !m_owner, (m_left == 1) && m_owner,
             m_left != 0, m_ovf, m_op, m_a, m_b, m_res});
      check("gnt_overlap", gnt0 & gnt1, 0);
      check("done_overlap", done0 & done1, 0);
    end
  end

  task automatic do_op(input bit r, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_lo, input logic exp_ovf, input string name);
    int n;
    if (r) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
    else   begin req0 = 1; op0 = op; a0 = a; b0 = b; end
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!(r ? gnt1 : gnt0) && n < 20);
    check({name, "_gnt"}, r ? gnt1 : gnt0, 1);
    if (r) req1 = 0; else req0 = 0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!(r ? done1 : done0) && n < 20);
    check({name, "_done"}, r ? done1 : done0, 1);
    check({name, "_res_lo"}, result[7:0], exp_lo);
    check({name, "_ovf"}, ovf, exp_ovf);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2; reset = 1;
    @(negedge clk); #2; reset = 0;
  endtask

  int gseq[$];

  initial begin
    reset = 1; req0 = 0; req1 = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    @(posedge clk); #1 started = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2; reset = 0;

    #1;
    check("reset_outputs", {gnt0, gnt1, done0, done1, busy, ovf, alu_opcode, alu_r1, alu_r2, result}, 0);

    // AND F0 & 3C with exact latency
    @(negedge clk); #2; req0 = 1; op0 = 2'b00; a0 = 8'hF0; b0 = 8'h3C;
    @(negedge clk); #1;
    check("t1_gnt0", {gnt0, gnt1, busy, done0}, 4'b1010);
    req0 = 0;
    @(negedge clk); #1;
    check("t1_done0", {done0, done1, busy, gnt0}, 4'b1010);
    check("t1_result", result, 16'h0030);
    check("t1_ovf", ovf, 0);
    @(negedge clk); #1;
    check("t1_idle", busy, 0);

    #1; do_op(1, 2'b11, 8'hFF, 8'h01, 8'h00, 1, "t2_add");
    #1; do_op(1, 2'b10, 8'h04, 8'h08, 8'h0C, 0, "t2_xor");

    // simultaneous requests right after reset
    pulse_reset();
    req0 = 1; op0 = 2'b01; a0 = 8'h04; b0 = 8'h08;
    req1 = 1; op1 = 2'b11; a1 = 8'h08; b1 = 8'h08;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      check($sformatf("tie_k%0d", k), {gnt0, done0, gnt1, done1},
            {k == 1, k == 2, k == 4, k == 5});
      if (k == 2) check("tie_res0", result[7:0], 8'h0C);
      if (k == 5) check("tie_res1", result[7:0], 8'h10);
      if (k == 1) req0 = 0;
      if (k == 4) req1 = 0;
    end

    // both held for 12 cycles
    @(negedge clk); #2;
    req0 = 1; req1 = 1; op0 = 2'b11; a0 = 8'h11; b0 = 8'h22; op1 = 2'b00; a1 = 8'hAA; b1 = 8'h0F;
    gseq = {};
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (gnt0) gseq.push_back(0);
      if (gnt1) gseq.push_back(1);
    end
    req0 = 0; req1 = 0;
    check("hold_count", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) begin
`ifdef MCPU_ALU_ARB_FIXED_PRIO_EN
      check($sformatf("hold_g%0d", i), gseq[i], 0);
`else
      check($sformatf("hold_g%0d", i), gseq[i], i % 2);
`endif
    end

`ifdef MCPU_ALU_ARB_FIXED_PRIO_EN
    // req0 drops after two grants; requester 1 then takes the next IDLE
    @(negedge clk); #2; @(negedge clk); #2;
    req0 = 1; req1 = 1;
    gseq = {};
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (gnt0) gseq.push_back(0);
      if (gnt1) gseq.push_back(1);
      if (k == 6) req0 = 0;
    end
    req1 = 0;
    check("fixed_count", gseq.size(), 4);
    if (gseq.size() == 4) check("fixed_seq", {gseq[0][0], gseq[1][0], gseq[2][0], gseq[3][0]}, 4'b0011);
`endif

    // reset during EXEC discards the op
    @(negedge clk); #2; @(negedge clk); #2;
    req0 = 1; op0 = 2'b01; a0 = 8'h55; b0 = 8'hAA;
    @(negedge clk); #1;
    check("rst_exec_gnt0", gnt0, 1);
    reset = 1; req0 = 0;
    @(negedge clk); #1;
    check("rst_exec_outputs", {gnt0, gnt1, done0, done1, busy, ovf, alu_opcode, alu_r1, alu_r2, result}, 0);
    reset = 0;
    @(negedge clk); #1;
    check("rst_exec_nodone", done0, 0);
    #1; do_op(0, 2'b11, 8'h12, 8'h34, 8'h46, 0, "post_rst");

    // random traffic with occasional reset
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #2;
      reset = ($urandom_range(0, 60) == 0);
      req0 = $urandom_range(0, 1); req1 = $urandom_range(0, 1);
      op0 = 2'($urandom); op1 = 2'($urandom);
      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    end
    @(negedge clk); #2; reset = 0; req0 = 0; req1 = 0;
    repeat (4) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
